// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: owner IDs, LS access types, FSM states.
package mem_arbiter_pkg;

  localparam int LSB_BURST_DEFAULT = 3;

  // Owner of the outstanding memory transaction
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Access width/sign encodings; stores only look at [1:0]
  localparam logic [2:0] TYPE_LW  = 3'b000;
  localparam logic [2:0] TYPE_LHU = 3'b001;
  localparam logic [2:0] TYPE_LBU = 3'b010;
  localparam logic [2:0] TYPE_LH  = 3'b101;
  localparam logic [2:0] TYPE_LB  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Width needed to count 0..burst inclusive
  function automatic int streak_width(input int burst);
    return (burst < 2) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between icache and LSB with bounded LSB priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int LSB_BURST = LSB_BURST_DEFAULT,
  parameter int STREAK_W  = 2
) (
  input  logic                ic_req,
  input  logic                ls_req,
  input  logic [STREAK_W-1:0] lsb_streak,
  input  logic                flush,
  input  logic                io_full,
  output logic                grant_valid,
  output logic                owner
);

  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(LSB_BURST);

  logic ic_eligible;

  // A flush blocks the fetch grant this cycle; LSB keeps priority until its streak is spent
  always_comb begin
    ic_eligible = ic_req && !flush;
    grant_valid = !io_full && (ic_eligible || ls_req);
    if (ls_req && (!ic_eligible || (lsb_streak < BURST_LIMIT))) begin
      owner = OWN_LS;
    end else begin
      owner = OWN_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer in front of the byte-serial memory controller: one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LSB_BURST = LSB_BURST_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        ic_req_in,
  input  logic [31:0] ic_addr_in,
  output logic        ic_ack_out,
  output logic        ic_valid_out,
  output logic [31:0] ic_data_out,
  input  logic        ls_req_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_data_in,
  input  logic        ls_r_nw_in,
  input  logic [2:0]  ls_type_in,
  output logic        ls_ack_out,
  output logic        ls_valid_out,
  output logic [31:0] ls_data_out,
  output logic        mc_activate_out,
  output logic [31:0] mc_addr_out,
  output logic [31:0] mc_data_out,
  output logic        mc_r_nw_out,
  output logic [2:0]  mc_type_out,
  input  logic [31:0] mc_data_in,
  input  logic        mc_done_in,
  input  logic        io_buffer_full_in,
  output logic        busy_out
);

  localparam int STREAK_W = streak_width(LSB_BURST);
  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(LSB_BURST);

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic                drop_ic_reg, drop_ic_next;
  logic                mc_activate_reg, mc_activate_next;
  logic [31:0]         mc_addr_reg, mc_addr_next;
  logic [31:0]         mc_data_reg, mc_data_next;
  logic                mc_r_nw_reg, mc_r_nw_next;
  logic [2:0]          mc_type_reg, mc_type_next;
  logic                ic_ack_reg, ic_ack_next;
  logic                ls_ack_reg, ls_ack_next;
  logic                ic_valid_reg, ic_valid_next;
  logic                ls_valid_reg, ls_valid_next;
  logic [31:0]         ic_data_reg, ic_data_next;
  logic [31:0]         ls_data_reg, ls_data_next;

  logic grant_valid;
  logic grant_owner;

  mem_arb_pick #(
    .LSB_BURST (LSB_BURST),
    .STREAK_W  (STREAK_W)
  ) u_pick (
    .ic_req      (ic_req_in),
    .ls_req      (ls_req_in),
    .lsb_streak  (streak_reg),
    .flush       (flush_in),
    .io_full     (io_buffer_full_in),
    .grant_valid (grant_valid),
    .owner       (grant_owner)
  );

  // Next-state logic: everything holds while rdy_in is low, so pulses stretch
  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    streak_next      = streak_reg;
    drop_ic_next     = drop_ic_reg;
    mc_activate_next = mc_activate_reg;
    mc_addr_next     = mc_addr_reg;
    mc_data_next     = mc_data_reg;
    mc_r_nw_next     = mc_r_nw_reg;
    mc_type_next     = mc_type_reg;
    ic_ack_next      = ic_ack_reg;
    ls_ack_next      = ls_ack_reg;
    ic_valid_next    = ic_valid_reg;
    ls_valid_next    = ls_valid_reg;
    ic_data_next     = ic_data_reg;
    ls_data_next     = ls_data_reg;
    if (rdy_in) begin
      ic_ack_next   = 1'b0;
      ls_ack_next   = 1'b0;
      ic_valid_next = 1'b0;
      ls_valid_next = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          drop_ic_next = 1'b0;
          if (grant_valid) begin
            state_next       = ST_BUSY;
            mc_activate_next = 1'b1;
            owner_next       = grant_owner;
            if (grant_owner == OWN_LS) begin
              ls_ack_next  = 1'b1;
              mc_addr_next = ls_addr_in;
              mc_data_next = ls_data_in;
              mc_r_nw_next = ls_r_nw_in;
              mc_type_next = ls_type_in;
              // Streak only grows while the icache is actually being held off
              if (ic_req_in) begin
                if (streak_reg < BURST_LIMIT) streak_next = streak_reg + 1'b1;
              end else begin
                streak_next = '0;
              end
            end else begin
              ic_ack_next  = 1'b1;
              mc_addr_next = ic_addr_in;
              mc_data_next = '0;
              mc_r_nw_next = 1'b1;
              mc_type_next = TYPE_LW;
              streak_next  = '0;
            end
          end
        end
        ST_BUSY: begin
          if ((owner_reg == OWN_IC) && flush_in) drop_ic_next = 1'b1;
          if (mc_done_in) begin
            state_next       = ST_IDLE;
            mc_activate_next = 1'b0;
            drop_ic_next     = 1'b0;
            if (owner_reg == OWN_LS) begin
              ls_valid_next = 1'b1;
              ls_data_next  = mc_r_nw_reg ? mc_data_in : 32'd0;
            end else if (!(drop_ic_reg || flush_in)) begin
              // A flush landing on the done edge also makes the fetch stale
              ic_valid_next = 1'b1;
              ic_data_next  = mc_data_in;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= OWN_IC;
      streak_reg      <= '0;
      drop_ic_reg     <= 1'b0;
      mc_activate_reg <= 1'b0;
      mc_addr_reg     <= '0;
      mc_data_reg     <= '0;
      mc_r_nw_reg     <= 1'b0;
      mc_type_reg     <= '0;
      ic_ack_reg      <= 1'b0;
      ls_ack_reg      <= 1'b0;
      ic_valid_reg    <= 1'b0;
      ls_valid_reg    <= 1'b0;
      ic_data_reg     <= '0;
      ls_data_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      streak_reg      <= streak_next;
      drop_ic_reg     <= drop_ic_next;
      mc_activate_reg <= mc_activate_next;
      mc_addr_reg     <= mc_addr_next;
      mc_data_reg     <= mc_data_next;
      mc_r_nw_reg     <= mc_r_nw_next;
      mc_type_reg     <= mc_type_next;
      ic_ack_reg      <= ic_ack_next;
      ls_ack_reg      <= ls_ack_next;
      ic_valid_reg    <= ic_valid_next;
      ls_valid_reg    <= ls_valid_next;
      ic_data_reg     <= ic_data_next;
      ls_data_reg     <= ls_data_next;
    end
  end

  assign ic_ack_out      = ic_ack_reg;
  assign ic_valid_out    = ic_valid_reg;
  assign ic_data_out     = ic_data_reg;
  assign ls_ack_out      = ls_ack_reg;
  assign ls_valid_out    = ls_valid_reg;
  assign ls_data_out     = ls_data_reg;
  assign mc_activate_out = mc_activate_reg;
  assign mc_addr_out     = mc_addr_reg;
  assign mc_data_out     = mc_data_reg;
  assign mc_r_nw_out     = mc_r_nw_reg;
  assign mc_type_out     = mc_type_reg;
  assign busy_out        = (state_reg != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter in front of the byte-serial memory controller. It accepts instruction-fetch requests from the icache and load/store requests from the LSB, and grants one at a time with bounded LSB priority. It drives the controller's single request port and routes the completed 32-bit result back to the requester as a one-cycle valid pulse. A pipeline flush discards in-flight fetch results without disturbing LSB traffic.

## Interface
- LSB_BURST, 3: maximum consecutive LSB grants while the icache is also requesting.
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when low, all registers hold.
- flush_in  in  1  pipeline flush (mispredict).
- ic_req_in  in  1  fetch request, level-held until ack.
- ic_addr_in  in  32  fetch address. Fetches are always LW (type 3'b000), read.
- ic_ack_out  out  1  one-cycle pulse: fetch accepted.
- ic_valid_out  out  1  one-cycle pulse: ic_data_out valid.
- ic_data_out  out  32  fetched word.
- ls_req_in  in  1  LSB request, level-held until ack.
- ls_addr_in  in  32  LSB address.
- ls_data_in  in  32  store data.
- ls_r_nw_in  in  1  1 = load, 0 = store.
- ls_type_in  in  3  width/sign type: 000 LW, 001 LHU, 010 LBU, 101 LH, 110 LB; stores use [1:0] only.
- ls_ack_out  out  1  one-cycle pulse: LSB request accepted.
- ls_valid_out  out  1  one-cycle pulse: load data or store completion.
- ls_data_out  out  32  load result; 0 for stores.
- mc_activate_out  out  1  request to the memory controller.
- mc_addr_out, mc_data_out  out  32 each  latched address and store data.
- mc_r_nw_out  out  1  latched read/not-write.
- mc_type_out  out  3  latched type.
- mc_data_in  in  32  controller result.
- mc_done_in  in  1  controller data_available; high for one cycle.
- io_buffer_full_in  in  1  I/O back-pressure.
- busy_out  out  1  high whenever state ≠ IDLE.

## Operation
- The arbiter has two states.
  - IDLE: evaluate requests.
  - BUSY: one transaction outstanding.
- Grant in IDLE happens only when rdy_in=1, io_buffer_full_in=0 and at least one request is present.
  - Only one requester present: that one wins.
  - Both present: LSB wins if lsb_streak < LSB_BURST, otherwise icache wins.
- lsb_streak counter:
  - Increments on each LSB grant made while ic_req_in=1.
  - Clears on any icache grant, or when the LSB is granted with ic_req_in=0.
  - Saturates at LSB_BURST.
- On grant:
  - Latch addr/data/r_nw/type and owner into the mc_* registers.
  - mc_activate_out ← 1, the winner's ack_out ← 1 for one cycle, state ← BUSY.
- BUSY:
  - The arbiter holds all mc_* outputs stable and ignores new requests.
  - On mc_done_in=1: capture mc_data_in into the owner's data register, pulse the owner's valid, set mc_activate_out ← 0, state ← IDLE.
  - For a store, capture 0 and pulse ls_valid_out.
- Flush:
  - If flush_in=1 while the owner is icache (BUSY), set drop_ic. The memory transaction still completes, but ic_valid_out is suppressed.
  - drop_ic clears on return to IDLE.
  - flush_in=1 in IDLE with ic_req_in=1 blocks the icache grant that cycle.
  - flush_in has no effect on an LSB-owned transaction.
- Reset (rst_in=0, asynchronous):
  - state=IDLE, lsb_streak=0, drop_ic=0.
  - All outputs 0, including mc_addr/data/type.
  - A transaction in progress is abandoned; the controller is reset by the same event.

## Timing
- Request sampled at edge E → ack_out and mc_activate_out high in the cycle after E.
- mc_done_in sampled at edge D → valid_out/data_out high in the cycle after D, together with mc_activate_out=0. The activate drop is registered, so it lands while the controller is still clearing data_available; this prevents the controller from re-launching the request.
- The earliest next grant is at edge D+1. Back-to-back issue therefore has one idle mc cycle.
- The requester must not assume acceptance before ack_out. It may change req/addr in the cycle ack_out is high.
- rdy_in=0 freezes everything: pulses stretch, and done is not sampled.
- mc_done_in in IDLE is ignored.

## Structure
- Shared macros file:
  - LS type encodings (LW/LHU/LBU/LH/LB).
  - Owner ID constants OWN_IC=1'b0, OWN_LS=1'b1.
  - State encodings.
- One sub-module, mem_arb_pick: combinational winner selection from (ic_req, ls_req, lsb_streak, flush, io_full), returning a grant_valid and owner.

## Test plan
- **LSB load, idle icache.** LSB load LW at 0x1000. Model returns done after 5 cycles with 0xDEADBEEF. Expect: ls_ack pulse; mc_type=000; ls_valid with 0xDEADBEEF; busy_out falls the same cycle.
- **Contention with LSB_BURST=3.** ic_req and ls_req held high continuously. Expect grant order LS,LS,LS,IC,LS,LS,LS,IC.
- **Flush during fetch.** Fetch at 0x0040; flush_in pulses mid-BUSY. Expect: done arrives, ic_valid_out stays 0, state returns to IDLE, a pending LSB request is granted next.
- **Store completion.** Store SB at 0x30000, data 0x41, with io_buffer_full_in=1 for 4 cycles. Expect: no grant during those cycles, grant after release, mc_r_nw=0, ls_valid with ls_data_out=0.
- **Reset mid-op.** rst_in low asynchronously while BUSY. Expect all outputs 0 immediately. After release, a pending fetch is granted normally.
- **rdy_in stall.** rdy_in=0 for 3 cycles across a done edge. Expect state and outputs frozen; completion is delivered exactly once after rdy_in returns.
